// File: rtl/parport_pkg.sv
// Shared defaults for the parallel port and its pad input conditioning stage.
package parport_pkg;

   localparam int PP_WIDTH    = 32;
   localparam int PP_PRESCALE = 1000;
   localparam int PP_STABLE   = 4;

endpackage : parport_pkg

// File: rtl/pad_debounce_if.sv
// Signal bundle between the raw pads and the debounced word fed to the parallel port.
interface pad_debounce_if
   import parport_pkg::*;
#(
   parameter int WIDTH = PP_WIDTH
);

   // No valid/ready pair here: pad_i is a free-running level; the outputs change only
   // on clk edges, change_o acts as a per-bit one-cycle strobe and tick_o as a sample strobe.
   logic [WIDTH-1:0] pad_i;
   logic [WIDTH-1:0] in_pad_o;
   logic [WIDTH-1:0] change_o;
   logic             tick_o;

   modport master (
      output pad_i,
      input  in_pad_o,
      input  change_o,
      input  tick_o
   );

   modport slave (
      input  pad_i,
      output in_pad_o,
      output change_o,
      output tick_o
   );

endinterface : pad_debounce_if

// File: rtl/pad_debounce_sync.sv
// Plain two-flop synchroniser for asynchronous level inputs, synchronous active-low reset.
module pad_sync
   import parport_pkg::*;
#(
   parameter int WIDTH = PP_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Direct flop-to-flop path: nothing may sit between the two stages.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : pad_sync

// File: rtl/pad_debounce.sv
// Synchronises and debounces up to WIDTH pad inputs on a shared prescaled sample tick.
module pad_debounce
   import parport_pkg::*;
#(
   parameter int WIDTH    = PP_WIDTH,
   parameter int PRESCALE = PP_PRESCALE,
   parameter int STABLE   = PP_STABLE
) (
   input  logic           clk,
   input  logic           rst_n,
   pad_debounce_if.slave  bus
);

   localparam int             CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(PRESCALE - 1);

   if (PRESCALE < 2 || STABLE < 2) begin : g_param_check
      $error("pad_debounce: PRESCALE and STABLE must both be >= 2");
   end

   logic [CW-1:0]     cnt_q, cnt_d;
   logic              tick;
   logic [WIDTH-1:0]  sync;
   logic [STABLE-1:0] hist_q [WIDTH];
   logic [STABLE-1:0] hist_d [WIDTH];
   logic [WIDTH-1:0]  in_pad_q, in_pad_d;
   logic [WIDTH-1:0]  change_q, change_d;

   pad_sync #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.pad_i),
      .q_o   (sync)
   );

   // Wrap straight from the tick cycle back to zero: no dead cycle between periods.
   assign tick  = (cnt_q == CNT_MAX);
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);

   always_comb begin
      in_pad_d = in_pad_q;
      change_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         hist_d[i] = hist_q[i];
         if (tick) begin
            hist_d[i] = {hist_q[i][STABLE-2:0], sync[i]};
            if ((&hist_d[i]) && !in_pad_q[i]) begin
               in_pad_d[i] = 1'b1;
               change_d[i] = 1'b1;
            end else if (!(|hist_d[i]) && in_pad_q[i]) begin
               in_pad_d[i] = 1'b0;
               change_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         hist_q   <= '{default: '0};
         in_pad_q <= '0;
         change_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         hist_q   <= hist_d;
         in_pad_q <= in_pad_d;
         change_q <= change_d;
      end
   end

   assign bus.in_pad_o = in_pad_q;
   assign bus.change_o = change_q;
   assign bus.tick_o   = tick;

endmodule : pad_debounce
